// File: rtl/banco_reg_multipuerto.sv
// Multiported register file: one sync write, two comb reads with bypass,
// and a pending-write scoreboard with a registered busy counter.
module banco_reg_multipuerto #(
    parameter int WIDTH    = 28,
    parameter int DEPTH    = 16,
    parameter int ZERO_REG = 1,
    parameter int BYPASS   = 1,
    localparam int AW      = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             eneable,
    input  logic             we,
    input  logic [AW-1:0]    wa,
    input  logic [WIDTH-1:0] wd,
    input  logic [AW-1:0]    ra1,
    input  logic [AW-1:0]    ra2,
    output logic [WIDTH-1:0] rd1,
    output logic [WIDTH-1:0] rd2,
    input  logic             set_busy,
    input  logic [AW-1:0]    sb_addr,
    output logic             busy1,
    output logic             busy2,
    output logic [AW:0]      pend_cnt
);

    localparam bit ZR  = (ZERO_REG != 0);
    localparam bit BYP = (BYPASS != 0);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [DEPTH-1:0] busy;
    logic [DEPTH-1:0] busy_nxt;

    logic             wr_ok;
    logic             sb_ok;
    logic             inc;
    logic             dec;
    logic [AW:0]      inc_v;
    logic [AW:0]      dec_v;

    assign wr_ok = eneable && we && !(ZR && (wa == '0));
    assign sb_ok = eneable && set_busy && !(ZR && (sb_addr == '0));

    // Reservation wins over writeback on the same address.
    always_comb begin
        busy_nxt = busy;
        for (int i = 0; i < DEPTH; i++) begin
            if (wr_ok && (wa == AW'(i)))
                busy_nxt[i] = 1'b0;
            if (sb_ok && (sb_addr == AW'(i)))
                busy_nxt[i] = 1'b1;
        end
    end

    assign inc   = sb_ok && !busy[sb_addr];
    assign dec   = wr_ok && busy[wa] && !(sb_ok && (sb_addr == wa));
    assign inc_v = {{AW{1'b0}}, inc};
    assign dec_v = {{AW{1'b0}}, dec};

    always_ff @(posedge clk) begin
        if (reset) begin
            for (int i = 0; i < DEPTH; i++)
                mem[i] <= '0;
            busy     <= '0;
            pend_cnt <= '0;
        end else begin
            if (wr_ok)
                mem[wa] <= wd;
            busy     <= busy_nxt;
            pend_cnt <= pend_cnt + inc_v - dec_v;
        end
    end

    logic byp1;
    logic byp2;
    logic sb_hit1;
    logic sb_hit2;

    assign byp1    = BYP && !reset && wr_ok && (wa == ra1);
    assign byp2    = BYP && !reset && wr_ok && (wa == ra2);
    assign sb_hit1 = sb_ok && (sb_addr == ra1);
    assign sb_hit2 = sb_ok && (sb_addr == ra2);

    always_comb begin
        rd1   = mem[ra1];
        busy1 = busy[ra1];
        if (ZR && (ra1 == '0)) begin
            rd1   = '0;
            busy1 = 1'b0;
        end else if (byp1) begin
            rd1   = wd;
            busy1 = sb_hit1;
        end
    end

    always_comb begin
        rd2   = mem[ra2];
        busy2 = busy[ra2];
        if (ZR && (ra2 == '0)) begin
            rd2   = '0;
            busy2 = 1'b0;
        end else if (byp2) begin
            rd2   = wd;
            busy2 = sb_hit2;
        end
    end

endmodule

// File: tb/tb_banco_reg_multipuerto.sv
// Directed bench: a bypassing and a non-bypassing instance share stimulus.
// Each scenario task checks its own hand-computed expectations inline.
module tb_banco_reg_multipuerto;

    localparam int W  = 28;
    localparam int AW = 4;

    logic          clk = 1'b0;
    logic          reset;
    logic          eneable;
    logic          we;
    logic [AW-1:0] wa;
    logic [W-1:0]  wd;
    logic [AW-1:0] ra1;
    logic [AW-1:0] ra2;
    logic          set_busy;
    logic [AW-1:0] sb_addr;

    logic [W-1:0]  b_rd1, b_rd2, n_rd1, n_rd2;
    logic          b_bz1, b_bz2, n_bz1, n_bz2;
    logic [AW:0]   b_cnt, n_cnt;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    banco_reg_multipuerto #(.WIDTH(W), .DEPTH(16), .ZERO_REG(1), .BYPASS(1)) u_byp (
        .clk(clk), .reset(reset), .eneable(eneable), .we(we), .wa(wa), .wd(wd),
        .ra1(ra1), .ra2(ra2), .rd1(b_rd1), .rd2(b_rd2), .set_busy(set_busy),
        .sb_addr(sb_addr), .busy1(b_bz1), .busy2(b_bz2), .pend_cnt(b_cnt)
    );

    banco_reg_multipuerto #(.WIDTH(W), .DEPTH(16), .ZERO_REG(1), .BYPASS(0)) u_nob (
        .clk(clk), .reset(reset), .eneable(eneable), .we(we), .wa(wa), .wd(wd),
        .ra1(ra1), .ra2(ra2), .rd1(n_rd1), .rd2(n_rd2), .set_busy(set_busy),
        .sb_addr(sb_addr), .busy1(n_bz1), .busy2(n_bz2), .pend_cnt(n_cnt)
    );

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic idle;
        we       = 1'b0;
        set_busy = 1'b0;
        reset    = 1'b0;
        eneable  = 1'b1;
    endtask

    task automatic test_reset;
        reset = 1'b1; eneable = 1'b1; we = 1'b1; wa = 4'd3; wd = 28'hABCDEF0;
        set_busy = 1'b0; sb_addr = 4'd0; ra1 = 4'd0; ra2 = 4'd0;
        step();
        idle();
        for (int i = 0; i < 16; i++) begin
            ra1 = AW'(i); ra2 = AW'(15 - i);
            #1;
            n_cmp++;
            if ({b_rd1, b_rd2, n_rd1, n_rd2} !== '0) begin
                n_err++;
                $display("FAIL reset_rd ra=%0d: got %h %h %h %h want 0", i, b_rd1, b_rd2, n_rd1, n_rd2);
            end
            n_cmp++;
            if ({b_bz1, b_bz2, n_bz1, n_bz2} !== 4'b0) begin
                n_err++;
                $display("FAIL reset_busy ra=%0d: got %b%b%b%b want 0000", i, b_bz1, b_bz2, n_bz1, n_bz2);
            end
        end
        n_cmp++;
        if (b_cnt !== 5'd0 || n_cnt !== 5'd0) begin
            n_err++;
            $display("FAIL reset_cnt: got %0d/%0d want 0", b_cnt, n_cnt);
        end
    endtask

    task automatic test_write;
        we = 1'b1; wa = 4'd5; wd = 28'h0FFFFFF; ra1 = 4'd5; ra2 = 4'd5;
        #1;
        n_cmp++;
        if (b_rd2 !== 28'h0FFFFFF) begin
            n_err++;
            $display("FAIL write_bypass: got %h want 0ffffff", b_rd2);
        end
        n_cmp++;
        if (n_rd2 !== 28'h0) begin
            n_err++;
            $display("FAIL write_nobypass: got %h want 0000000", n_rd2);
        end
        step();
        idle();
        #1;
        n_cmp++;
        if (n_rd1 !== 28'h0FFFFFF || b_rd1 !== 28'h0FFFFFF) begin
            n_err++;
            $display("FAIL write_next: got %h/%h want 0ffffff", b_rd1, n_rd1);
        end
    endtask

    task automatic test_zero_reg;
        we = 1'b1; wa = 4'd0; wd = 28'h1234567;
        set_busy = 1'b1; sb_addr = 4'd0; ra1 = 4'd0;
        #1;
        n_cmp++;
        if (b_rd1 !== 28'h0 || b_bz1 !== 1'b0) begin
            n_err++;
            $display("FAIL zero_same: got rd=%h busy=%b want 0/0", b_rd1, b_bz1);
        end
        step();
        idle();
        #1;
        n_cmp++;
        if (b_rd1 !== 28'h0 || n_rd1 !== 28'h0 || b_bz1 !== 1'b0 || n_bz1 !== 1'b0) begin
            n_err++;
            $display("FAIL zero_after: got rd=%h/%h busy=%b/%b want 0", b_rd1, n_rd1, b_bz1, n_bz1);
        end
        n_cmp++;
        if (b_cnt !== 5'd0 || n_cnt !== 5'd0) begin
            n_err++;
            $display("FAIL zero_cnt: got %0d/%0d want 0", b_cnt, n_cnt);
        end
    endtask

    task automatic test_scoreboard;
        logic [4:0] exp_c;
        for (int i = 2; i <= 4; i++) begin
            set_busy = 1'b1; sb_addr = AW'(i); ra1 = AW'(i);
            #1;
            n_cmp++;
            if (b_bz1 !== 1'b0) begin
                n_err++;
                $display("FAIL sb_nobyp r%0d: got %b want 0", i, b_bz1);
            end
            step();
            idle();
            #1;
            exp_c = 5'(i - 1);
            n_cmp++;
            if (b_cnt !== exp_c || n_cnt !== exp_c || b_bz1 !== 1'b1) begin
                n_err++;
                $display("FAIL sb_set r%0d: got cnt=%0d/%0d busy=%b want %0d/1", i, b_cnt, n_cnt, b_bz1, exp_c);
            end
        end
        we = 1'b1; wa = 4'd3; wd = 28'h33; set_busy = 1'b1; sb_addr = 4'd7;
        ra1 = 4'd3; ra2 = 4'd7;
        #1;
        n_cmp++;
        if (b_bz1 !== 1'b0 || n_bz1 !== 1'b1 || b_bz2 !== 1'b0) begin
            n_err++;
            $display("FAIL sb_clr_byp: got %b/%b/%b want 0/1/0", b_bz1, n_bz1, b_bz2);
        end
        step();
        idle();
        #1;
        n_cmp++;
        if (b_cnt !== 5'd3 || n_cnt !== 5'd3) begin
            n_err++;
            $display("FAIL sb_swap_cnt: got %0d/%0d want 3", b_cnt, n_cnt);
        end
        n_cmp++;
        if (n_bz1 !== 1'b0 || n_bz2 !== 1'b1 || n_rd1 !== 28'h33) begin
            n_err++;
            $display("FAIL sb_swap_bits: got b3=%b b7=%b rd=%h want 0 1 33", n_bz1, n_bz2, n_rd1);
        end
    endtask

    task automatic test_same_addr;
        we = 1'b1; wa = 4'd9; wd = 28'h55; set_busy = 1'b1; sb_addr = 4'd9; ra1 = 4'd9;
        #1;
        n_cmp++;
        if (b_rd1 !== 28'h55 || b_bz1 !== 1'b1) begin
            n_err++;
            $display("FAIL same_byp: got rd=%h busy=%b want 55/1", b_rd1, b_bz1);
        end
        n_cmp++;
        if (n_rd1 !== 28'h0 || n_bz1 !== 1'b0) begin
            n_err++;
            $display("FAIL same_nobyp: got rd=%h busy=%b want 0/0", n_rd1, n_bz1);
        end
        step();
        idle();
        #1;
        n_cmp++;
        if (n_rd1 !== 28'h55 || n_bz1 !== 1'b1 || b_cnt !== 5'd4 || n_cnt !== 5'd4) begin
            n_err++;
            $display("FAIL same_after: got rd=%h busy=%b cnt=%0d/%0d want 55 1 4", n_rd1, n_bz1, b_cnt, n_cnt);
        end
    endtask

    task automatic test_enable;
        eneable = 1'b0; we = 1'b1; wa = 4'd6; wd = 28'h77;
        set_busy = 1'b1; sb_addr = 4'd8; ra1 = 4'd6; ra2 = 4'd8;
        #1;
        n_cmp++;
        if (b_rd1 !== 28'h0) begin
            n_err++;
            $display("FAIL en_byp_off: got %h want 0", b_rd1);
        end
        step();
        #1;
        n_cmp++;
        if (b_rd1 !== 28'h0 || b_bz2 !== 1'b0 || b_cnt !== 5'd4) begin
            n_err++;
            $display("FAIL en_frozen: got rd=%h busy=%b cnt=%0d want 0 0 4", b_rd1, b_bz2, b_cnt);
        end
        eneable = 1'b1;
        step();
        idle();
        #1;
        n_cmp++;
        if (n_rd1 !== 28'h77 || n_bz2 !== 1'b1 || n_cnt !== 5'd5 || b_cnt !== 5'd5) begin
            n_err++;
            $display("FAIL en_resume: got rd=%h busy=%b cnt=%0d/%0d want 77 1 5", n_rd1, n_bz2, n_cnt, b_cnt);
        end
    endtask

    task automatic test_back_to_back;
        we = 1'b1; wa = 4'd2; wd = 28'h22; set_busy = 1'b1; sb_addr = 4'd11;
        step();
        n_cmp++;
        if (b_cnt !== 5'd5) begin
            n_err++;
            $display("FAIL b2b_net0: got %0d want 5", b_cnt);
        end
        we = 1'b1; wa = 4'd9; wd = 28'h99; set_busy = 1'b0;
        step();
        n_cmp++;
        if (b_cnt !== 5'd4) begin
            n_err++;
            $display("FAIL b2b_dec: got %0d want 4", b_cnt);
        end
        we = 1'b0; set_busy = 1'b1; sb_addr = 4'd4;
        step();
        n_cmp++;
        if (b_cnt !== 5'd4) begin
            n_err++;
            $display("FAIL b2b_rebusy: got %0d want 4", b_cnt);
        end
        we = 1'b1; wa = 4'd10; wd = 28'hA0; set_busy = 1'b0;
        step();
        idle();
        ra1 = 4'd11; ra2 = 4'd2;
        #1;
        n_cmp++;
        if (n_cnt !== 5'd4 || n_bz1 !== 1'b1 || n_bz2 !== 1'b0 || n_rd2 !== 28'h22) begin
            n_err++;
            $display("FAIL b2b_final: got cnt=%0d b11=%b b2=%b rd=%h want 4 1 0 22", n_cnt, n_bz1, n_bz2, n_rd2);
        end
    endtask

    task automatic test_mid_reset;
        reset = 1'b1; we = 1'b1; wa = 4'd12; wd = 28'hAA; set_busy = 1'b1; sb_addr = 4'd13;
        ra1 = 4'd12; ra2 = 4'd9;
        #1;
        n_cmp++;
        if (b_rd1 !== 28'h0) begin
            n_err++;
            $display("FAIL rst_byp_off: got %h want 0", b_rd1);
        end
        step();
        idle();
        #1;
        n_cmp++;
        if (b_cnt !== 5'd0 || n_rd1 !== 28'h0 || n_rd2 !== 28'h0 || n_bz2 !== 1'b0) begin
            n_err++;
            $display("FAIL rst_mid: got cnt=%0d rd12=%h rd9=%h b9=%b want 0", b_cnt, n_rd1, n_rd2, n_bz2);
        end
        ra1 = 4'd13;
        #1;
        n_cmp++;
        if (n_bz1 !== 1'b0) begin
            n_err++;
            $display("FAIL rst_resv_drop: got %b want 0", n_bz1);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_zero_reg();
        test_scoreboard();
        test_same_addr();
        test_enable();
        test_back_to_back();
        test_mid_reset();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
